// File: rtl/wr_ptr_sync_level.sv
// Write-domain read-pointer synchronizer with fill level, almost-full and sticky overflow.
// Optional saturating overflow event counter on w_ovf_cnt_o when WR_OVF_CNT_EN is defined.
module wr_ptr_sync_level #(
    parameter int ADD_WIDTH   = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 w_clk_i,
    input  logic                 rst_n_i,
    input  logic [ADD_WIDTH:0]   r_g_addr_async_i,
    input  logic [ADD_WIDTH:0]   w_addr_bin_i,
    input  logic                 w_req_i,
    input  logic                 w_full_i,
    input  logic [ADD_WIDTH:0]   af_thresh_i,
    input  logic                 w_ovf_clr_i,
    output logic [ADD_WIDTH:0]   r_g_addr_sync_o,
    output logic [ADD_WIDTH:0]   w_level_o,
    output logic                 w_almost_full_o,
`ifdef WR_OVF_CNT_EN
    output logic [15:0]          w_ovf_cnt_o,
`endif
    output logic                 w_overflow_o
);

    logic [SYNC_STAGES-1:0][ADD_WIDTH:0] sync_q;
    logic [ADD_WIDTH:0]                  r_bin;
    logic [ADD_WIDTH:0]                  level_d, level_q;
    logic                                af_d, af_q;
    logic                                ovf_d, ovf_q;
    logic                                ovf_ev;

    // Only the Gray value crosses domains; the chain has no logic between stages.
    always_ff @(posedge w_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= r_g_addr_async_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign r_g_addr_sync_o = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits at or above i.
    for (genvar i = 0; i <= ADD_WIDTH; i++) begin : g_g2b
        assign r_bin[i] = ^r_g_addr_sync_o[ADD_WIDTH:i];
    end

    assign ovf_ev = w_req_i && w_full_i;

    always_comb begin
        level_d = w_addr_bin_i - r_bin;
        af_d    = (level_d >= af_thresh_i);
        ovf_d   = ovf_q;
        if (w_ovf_clr_i) ovf_d = 1'b0;
        if (ovf_ev)      ovf_d = 1'b1;
    end

    always_ff @(posedge w_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            level_q <= '0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_level_o       = level_q;
    assign w_almost_full_o = af_q;
    assign w_overflow_o    = ovf_q;

`ifdef WR_OVF_CNT_EN
    logic [15:0] cnt_d, cnt_q;

    // A clear coinciding with an event counts that event.
    always_comb begin
        cnt_d = cnt_q;
        if (w_ovf_clr_i)
            cnt_d = ovf_ev ? 16'd1 : 16'd0;
        else if (ovf_ev && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge w_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign w_ovf_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_wr_ptr_sync_level.sv
// Directed bench for wr_ptr_sync_level (ADD_WIDTH=9, SYNC_STAGES=2); counter checks need WR_OVF_CNT_EN.
module tb_wr_ptr_sync_level;

    logic       w_clk_i = 1'b0;
    logic       rst_n_i;
    logic [9:0] r_g_addr_async_i, w_addr_bin_i, af_thresh_i;
    logic       w_req_i, w_full_i, w_ovf_clr_i;
    logic [9:0] r_g_addr_sync_o, w_level_o;
    logic       w_almost_full_o, w_overflow_o;
`ifdef WR_OVF_CNT_EN
    logic [15:0] w_ovf_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    wr_ptr_sync_level #(.ADD_WIDTH(9), .SYNC_STAGES(2)) dut (
        .w_clk_i          (w_clk_i),
        .rst_n_i          (rst_n_i),
        .r_g_addr_async_i (r_g_addr_async_i),
        .w_addr_bin_i     (w_addr_bin_i),
        .w_req_i          (w_req_i),
        .w_full_i         (w_full_i),
        .af_thresh_i      (af_thresh_i),
        .w_ovf_clr_i      (w_ovf_clr_i),
        .r_g_addr_sync_o  (r_g_addr_sync_o),
        .w_level_o        (w_level_o),
        .w_almost_full_o  (w_almost_full_o),
`ifdef WR_OVF_CNT_EN
        .w_ovf_cnt_o      (w_ovf_cnt_o),
`endif
        .w_overflow_o     (w_overflow_o)
    );

    always #5 w_clk_i = ~w_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n edges; sample 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge w_clk_i);
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        r_g_addr_async_i = 10'h155;
        w_addr_bin_i = 10'h010;
        af_thresh_i = 10'd500;
        w_req_i = 1'b0; w_full_i = 1'b0; w_ovf_clr_i = 1'b0;
        tick(2);
        chk("rst_sync", r_g_addr_sync_o, 0);
        chk("rst_level", w_level_o, 0);
        chk("rst_af", w_almost_full_o, 0);
        chk("rst_ovf", w_overflow_o, 0);
`ifdef WR_OVF_CNT_EN
        chk("rst_cnt", w_ovf_cnt_o, 0);
`endif
        rst_n_i = 1'b1;
        tick(1);
        chk("rel_e1_sync", r_g_addr_sync_o, 0);
        chk("rel_e1_level", w_level_o, 16);
        tick(1);
        chk("rel_e2_sync", r_g_addr_sync_o, 10'h155);
        chk("rel_e2_level", w_level_o, 16);
        chk("rel_e2_af", w_almost_full_o, 0);
        tick(1);
        // gray 0x155 -> bin 0x199; 0x010 - 0x199 mod 1024 = 631
        chk("rel_e3_level", w_level_o, 631);
        chk("rel_e3_af", w_almost_full_o, 1);

        r_g_addr_async_i = 10'h200; w_addr_bin_i = 10'h002;
        tick(3);
        chk("wrap_level", w_level_o, 3);
        chk("wrap_af", w_almost_full_o, 0);

        r_g_addr_async_i = 10'h000; w_addr_bin_i = 10'h200;
        tick(3);
        chk("full_level", w_level_o, 512);
        chk("full_af", w_almost_full_o, 1);

        w_addr_bin_i = 10'd498; tick(1);
        chk("af498_level", w_level_o, 498);
        chk("af498", w_almost_full_o, 0);
        w_addr_bin_i = 10'd499; tick(1);
        chk("af499", w_almost_full_o, 0);
        w_addr_bin_i = 10'd500; tick(1);
        chk("af500_level", w_level_o, 500);
        chk("af500", w_almost_full_o, 1);
        w_addr_bin_i = 10'd501; tick(1);
        chk("af501", w_almost_full_o, 1);
        af_thresh_i = 10'd0; w_addr_bin_i = 10'd0; tick(1);
        chk("af_th0_level", w_level_o, 0);
        chk("af_th0", w_almost_full_o, 1);
        af_thresh_i = 10'd513; w_addr_bin_i = 10'h200; tick(1);
        chk("af_th513", w_almost_full_o, 0);
        af_thresh_i = 10'd500;

        w_req_i = 1'b1; w_full_i = 1'b0; tick(1);
        chk("ovf_req_only", w_overflow_o, 0);
        w_full_i = 1'b1; tick(1);
        chk("ovf_set", w_overflow_o, 1);
`ifdef WR_OVF_CNT_EN
        chk("cnt_1", w_ovf_cnt_o, 1);
`endif
        w_req_i = 1'b0; tick(1);
        chk("ovf_hold", w_overflow_o, 1);
        w_req_i = 1'b1; w_ovf_clr_i = 1'b1; tick(1);
        chk("ovf_set_wins", w_overflow_o, 1);
`ifdef WR_OVF_CNT_EN
        chk("cnt_clr_inc", w_ovf_cnt_o, 1);
`endif
        w_req_i = 1'b0; tick(1);
        chk("ovf_clr", w_overflow_o, 0);
        w_ovf_clr_i = 1'b0;

`ifdef WR_OVF_CNT_EN
        chk("cnt_clr", w_ovf_cnt_o, 0);
        w_req_i = 1'b1; tick(3);
        chk("cnt_3", w_ovf_cnt_o, 3);
        tick(70000);
        chk("cnt_sat", w_ovf_cnt_o, 16'hFFFF);
        w_ovf_clr_i = 1'b1; tick(1);
        chk("cnt_sat_clr_inc", w_ovf_cnt_o, 1);
        w_req_i = 1'b0; tick(1);
        chk("cnt_clr2", w_ovf_cnt_o, 0);
        w_ovf_clr_i = 1'b0;
`endif

        // gray(8) = 0xC; 208 - 8 = 200
        r_g_addr_async_i = 10'h00C; w_addr_bin_i = 10'd208;
        w_req_i = 1'b1; w_full_i = 1'b1; tick(3);
        w_req_i = 1'b0; w_full_i = 1'b0;
        chk("pre_rst_level", w_level_o, 200);
        chk("pre_rst_ovf", w_overflow_o, 1);
        rst_n_i = 1'b0; #1;
        chk("mid_rst_sync", r_g_addr_sync_o, 0);
        chk("mid_rst_level", w_level_o, 0);
        chk("mid_rst_af", w_almost_full_o, 0);
        chk("mid_rst_ovf", w_overflow_o, 0);
        tick(1);
        rst_n_i = 1'b1;
        tick(1);
        chk("mid_e1_level", w_level_o, 208);
        tick(1);
        chk("mid_e2_sync", r_g_addr_sync_o, 10'h00C);
        tick(1);
        chk("mid_e3_level", w_level_o, 200);
        chk("mid_e3_ovf", w_overflow_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
